register_file: RTL and testbench
================================

# register_file

Parametrised multi-entry successor to the single 16-bit `register_component`: an array of DEPTH registers, each WIDTH bits, with one synchronous write port and two asynchronous read ports. It feeds the ALU operand paths of the datapath. Entry 0 is hardwired to zero, and one entry is the stack pointer with its own reset value. A synchronous bulk clear and an optional write-to-read bypass are also provided.

## Interface
- WIDTH, 16, data width of every entry.
- DEPTH, 16, number of entries; must be a power of two, at least 4.
- ADDR_W, $clog2(DEPTH), address width; derived, do not override.
- SP_INDEX, 2, index of the stack-pointer entry; must be nonzero and less than DEPTH.
- SP_RESET, 16'h7FFE, value loaded into entry SP_INDEX on reset and on clear; truncated to WIDTH.

- clock  input  1  Single clock; all state updates on its rising edge.
- reset  input  1  Asynchronous, active-high reset.
- write  input  1  Write enable for the write port.
- write_addr  input  ADDR_W  Write port address.
- write_data  input  WIDTH  Write port data.
- clear  input  1  Synchronous bulk clear.
- read_addr_a  input  ADDR_W  Read port A address.
- read_data_a  output  WIDTH  Read port A data.
- read_addr_b  input  ADDR_W  Read port B address.
- read_data_b  output  WIDTH  Read port B data.

## Operation
- **Storage**
  - Entries 1 to DEPTH-1 are registers.
  - Entry 0 has no storage: it always reads 0, and writes to it are silently discarded.
- **Reset** (asserted at any time, including mid-write)
  - Takes effect immediately.
  - All entries become 0, except SP_INDEX, which becomes SP_RESET.
  - While reset is high, rising clock edges change nothing.
- **Clear**
  - Sampled on the rising edge; produces the same contents as reset.
  - Clear has priority over write in the same cycle; the write is lost.
- **Write**
  - On a rising edge with write=1, clear=0, reset=0 and write_addr≠0, the entry at write_addr takes write_data.
  - No other entry changes.
- **Read**
  - read_data_a and read_data_b are combinational functions of their address and the current contents.
  - Both ports may address the same entry and the write entry simultaneously.
- **Address range**
  - Because DEPTH is a power of two, every address is in range; there is no out-of-range case.
- **Widths**
  - There is no arithmetic in the block. SP_RESET is truncated to its low WIDTH bits.

## Timing
- Write latency:
  - Data written at edge N is visible on the read ports after edge N, within the same cycle's combinational settling.
  - Without bypass, a read of the write address during cycle N-1, before the edge, returns the old value.
- Read latency: zero cycles (combinational from address to data).
- Reset output values:
  - read_data_a and read_data_b equal 0, or SP_RESET when their address equals SP_INDEX.
  - Both follow the reset contents immediately on assertion of reset.
- Reset deassertion is synchronised externally; the block requires reset to be released with at least setup time before a rising edge.
- Simultaneous events:
  - reset over clear; clear over write.
  - A write to 0 is a no-op even when combined with bypass.

## Configuration
- REGISTER_FILE_BYPASS_EN defined:
  - Applies when write=1, clear=0, reset=0, write_addr≠0, and a read address equals write_addr.
  - That read port outputs write_data combinationally, during the same cycle before the edge.
  - Used by the single-cycle datapath to remove the read-after-write hazard.
- REGISTER_FILE_BYPASS_EN undefined:
  - Read ports show stored contents only.
  - No combinational path exists from write_data or write to the read ports.

## Test plan
- **Reset**
  - Stimulus: assert reset mid-cycle with defaults, then read addresses 0, 1, 2 and 15.
  - Required: 0x0000, 0x0000, 0x7FFE, 0x0000, with no clock edge needed.
- **Write and dual read**
  - Stimulus: write 0x0010 to address 5 and 0xBEEF to address 9 on successive edges, then set read_addr_a=5 and read_addr_b=9.
  - Required: read_data_a=0x0010, read_data_b=0xBEEF; every other entry unchanged.
- **Zero register**
  - Stimulus: write 0x1234 to address 0, then read address 0 on both ports.
  - Required: 0x0000.
- **Clear priority**
  - Stimulus: address 3 holds 0x00AA; in one cycle assert clear=1 and write=1 with write_addr=3, write_data=0x5555.
  - Required: after the edge, address 3 reads 0x0000 and address 2 reads 0x7FFE.
- **Bypass**
  - Stimulus: address 4 holds 0x0001; set write=1, write_addr=4, write_data=0x0002, read_addr_a=4, and sample before the edge.
  - Required: 0x0002 with REGISTER_FILE_BYPASS_EN defined, 0x0001 without; 0x0002 after the edge in both builds.
- **Asynchronous reset during a write**
  - Stimulus: write=1, write_addr=7, write_data=0xFFFF; pulse reset high for 3 ns spanning the rising edge.
  - Required: address 7 reads 0x0000 after the edge.

Source files
------------

// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH register array with one synchronous write port and two
// combinational read ports. Entry 0 reads as zero and ignores writes; entry SP_INDEX is the
// stack pointer and resets/clears to SP_RESET. Reset is asynchronous and active-high; clear is
// a synchronous bulk reload of the reset contents and wins over a same-cycle write.
//
// Build option: define REGISTER_FILE_BYPASS_EN to forward write_data combinationally to any
// read port addressing the entry being written this cycle. Without it the read ports show
// stored contents only.
module register_file #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned ADDR_W   = $clog2(DEPTH),
   parameter int unsigned SP_INDEX = 2,
   parameter logic [15:0] SP_RESET = 16'h7FFE
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              write,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [WIDTH-1:0]  write_data,
   input  logic              clear,
   input  logic [ADDR_W-1:0] read_addr_a,
   output logic [WIDTH-1:0]  read_data_a,
   input  logic [ADDR_W-1:0] read_addr_b,
   output logic [WIDTH-1:0]  read_data_b
);

   // Stack-pointer reset value, truncated (or zero-extended) to the entry width.
   localparam logic [WIDTH-1:0] SpResetVal = WIDTH'(SP_RESET);

   // Current contents of every entry as seen by the read ports; entry 0 is a constant.
   logic [WIDTH-1:0] entry [DEPTH];

   assign entry[0] = '0;

   for (genvar e = 1; e < DEPTH; e++) begin : g_entry
      localparam logic [WIDTH-1:0] ResetVal = (e == int'(SP_INDEX)) ? SpResetVal : '0;

      logic [WIDTH-1:0] value_q;

      // Reset and clear reload the entry's reset value; otherwise take an addressed write.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            value_q <= ResetVal;
         end else if (clear) begin
            value_q <= ResetVal;
         end else if (write && (write_addr == ADDR_W'(e))) begin
            value_q <= write_data;
         end
      end

      assign entry[e] = value_q;
   end

`ifdef REGISTER_FILE_BYPASS_EN
   logic fwd_valid;

   // A write that will actually land this edge; address 0 never forwards.
   assign fwd_valid = write && !clear && !reset && (write_addr != '0);

   // Read ports: forwarded write data on an address match, stored contents otherwise.
   always_comb begin
      read_data_a = entry[read_addr_a];
      read_data_b = entry[read_addr_b];
      if (fwd_valid && (read_addr_a == write_addr)) begin
         read_data_a = write_data;
      end
      if (fwd_valid && (read_addr_b == write_addr)) begin
         read_data_b = write_data;
      end
   end
`else
   // Read ports: stored contents only, no path from the write port.
   always_comb begin
      read_data_a = entry[read_addr_a];
      read_data_b = entry[read_addr_b];
   end
`endif

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file (default parameters). Directed steps from the test plan followed
// by randomized cycles, all checked against an array model of the register contents.
module tb_register_file;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        write = 1'b0;
   logic [3:0]  write_addr = '0;
   logic [15:0] write_data = '0;
   logic        clear = 1'b0;
   logic [3:0]  read_addr_a = '0;
   logic [15:0] read_data_a;
   logic [3:0]  read_addr_b = '0;
   logic [15:0] read_data_b;

   int vectors = 0;
   int miscompares = 0;

   // Reference contents: index 0 unused (always reads zero).
   logic [15:0] model [16];

   register_file dut (
      .clock       (clock),
      .reset       (reset),
      .write       (write),
      .write_addr  (write_addr),
      .write_data  (write_data),
      .clear       (clear),
      .read_addr_a (read_addr_a),
      .read_data_a (read_data_a),
      .read_addr_b (read_addr_b),
      .read_data_b (read_data_b)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) model[i] = 16'h0000;
      model[2] = 16'h7FFE;
   endfunction

   function automatic logic [15:0] exp_read(input logic [3:0] a);
      if (a == 4'd0) return 16'h0000;
`ifdef REGISTER_FILE_BYPASS_EN
      if (write && !clear && !reset && (a == write_addr)) return write_data;
`endif
      return model[a];
   endfunction

   task automatic check_reads(input string tag);
      check({tag, ".a"}, read_data_a, exp_read(read_addr_a));
      check({tag, ".b"}, read_data_b, exp_read(read_addr_b));
   endtask

   // Drive one cycle at the falling edge; check before and after the rising edge.
   task automatic drive(input logic w, input logic [3:0] wa, input logic [15:0] wd,
                        input logic clr, input logic [3:0] ra, input logic [3:0] rb,
                        input string tag);
      @(negedge clock);
      write = w; write_addr = wa; write_data = wd; clear = clr;
      read_addr_a = ra; read_addr_b = rb;
      #1;
      check_reads({tag, ".pre"});
      @(posedge clock);
      if (reset || clr) model_reset();
      else if (w && wa != 4'd0) model[wa] = wd;
      #1;
      check_reads({tag, ".post"});
   endtask

   // Walk every address on both ports with the write port idle.
   task automatic sweep(input string tag);
      @(negedge clock);
      write = 1'b0; clear = 1'b0;
      for (int i = 0; i < 16; i++) begin
         read_addr_a = 4'(i);
         read_addr_b = 4'(15 - i);
         #1;
         check_reads(tag);
      end
   endtask

   initial begin
      model_reset();

      // Reset mid-cycle, no clock edge needed.
      #2 reset = 1'b1;
      read_addr_a = 4'd0; read_addr_b = 4'd1; #1;
      check("rst.addr0", read_data_a, 16'h0000);
      check("rst.addr1", read_data_b, 16'h0000);
      read_addr_a = 4'd2; read_addr_b = 4'd15; #1;
      check("rst.addr2", read_data_a, 16'h7FFE);
      check("rst.addr15", read_data_b, 16'h0000);

      // Rising edges while reset is high change nothing.
      write = 1'b1; write_addr = 4'd5; write_data = 16'hAAAA; read_addr_a = 4'd5;
      @(posedge clock); #1;
      check("rst.hold", read_data_a, 16'h0000);
      @(negedge clock);
      write = 1'b0; reset = 1'b0;

      // Write and dual read.
      drive(1'b1, 4'd5, 16'h0010, 1'b0, 4'd5, 4'd9, "wr5");
      drive(1'b1, 4'd9, 16'hBEEF, 1'b0, 4'd5, 4'd9, "wr9");
      check("dual.a", read_data_a, 16'h0010);
      check("dual.b", read_data_b, 16'hBEEF);
      sweep("sweep1");

      // Zero register.
      drive(1'b1, 4'd0, 16'h1234, 1'b0, 4'd0, 4'd0, "zero");
      check("zero.a", read_data_a, 16'h0000);
      check("zero.b", read_data_b, 16'h0000);

      // Clear beats a same-cycle write.
      drive(1'b1, 4'd3, 16'h00AA, 1'b0, 4'd3, 4'd2, "pre_clr");
      check("clr.setup", read_data_a, 16'h00AA);
      drive(1'b1, 4'd3, 16'h5555, 1'b1, 4'd3, 4'd2, "clr");
      check("clr.addr3", read_data_a, 16'h0000);
      check("clr.addr2", read_data_b, 16'h7FFE);
      sweep("sweep2");

      // Bypass before the edge, stored value after it.
      drive(1'b1, 4'd4, 16'h0001, 1'b0, 4'd4, 4'd1, "byp_setup");
      @(negedge clock);
      write = 1'b1; write_addr = 4'd4; write_data = 16'h0002; read_addr_a = 4'd4;
      #1;
`ifdef REGISTER_FILE_BYPASS_EN
      check("byp.pre", read_data_a, 16'h0002);
`else
      check("byp.pre", read_data_a, 16'h0001);
`endif
      @(posedge clock);
      model[4] = 16'h0002;
      #1;
      check("byp.post", read_data_a, 16'h0002);

      // Asynchronous reset pulse spanning the edge of a write.
      drive(1'b1, 4'd7, 16'h1111, 1'b0, 4'd7, 4'd2, "ar_setup");
      @(negedge clock);
      write = 1'b1; write_addr = 4'd7; write_data = 16'hFFFF; read_addr_a = 4'd7;
      read_addr_b = 4'd2;
      #3.5 reset = 1'b1;
      #3 reset = 1'b0;
      model_reset();
      check("arst.addr7", read_data_a, 16'h0000);
      check("arst.addr2", read_data_b, 16'h7FFE);
      sweep("sweep3");

      // Randomized cycles.
      for (int n = 0; n < 300; n++) begin
         logic        w, clr;
         logic [3:0]  wa, ra, rb;
         logic [15:0] wd;
         w   = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 19) == 0);
         wa  = 4'($urandom_range(0, 15));
         wd  = 16'($urandom);
         ra  = ($urandom_range(0, 1) != 0) ? wa : 4'($urandom_range(0, 15));
         rb  = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
         drive(w, wa, wd, clr, ra, rb, "rand");
      end
      sweep("sweep4");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
